ecc_mem_ctrl: RTL and testbench

Controller that owns an array of `ecc_mem_word` cells (20-bit SECDED words). It serializes CPU read/write requests onto the array's single access port and interleaves a background scrubber that walks every address. On any correctable error, from a CPU read or a scrub read, it writes the corrected word back. It sits between the CPU load/store path and the ECC memory array.

---
 rtl/ecc_ctrl_pkg.sv | 14 +
 rtl/ecc_scrub_timer.sv | 50 +++++
 rtl/ecc_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_ecc_mem_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared definitions for the ECC memory controller: FSM state encoding and
// the SECDED word width the array cells are built for.
package ecc_ctrl_pkg;

  localparam int ECC_DATA_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SCRUB  = 2'd2,
    ST_FIX    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/ecc_scrub_timer.sv
// Background scrub pacing: interval counter, pending flag and the address
// pointer that walks the whole array one word per scrub.
module ecc_scrub_timer
  import ecc_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              scrub_take,
  output logic              scrub_pending,
  output logic [ADDR_W-1:0] scrub_ptr
);

  localparam int               CNT_W = $clog2(SCRUB_INTERVAL);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(SCRUB_INTERVAL - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             in_scrub;

  // An expiry while already pending just keeps the flag set; taking the scrub clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt      <= '0;
      scrub_pending <= 1'b0;
    end else if (!scrub_en) begin
      tick_cnt      <= '0;
      scrub_pending <= 1'b0;
    end else begin
      if (tick_cnt == TERM) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + 1'b1;
      if (scrub_take)            scrub_pending <= 1'b0;
      else if (tick_cnt == TERM) scrub_pending <= 1'b1;
    end
  end

  // in_scrub mirrors the FSM's SCRUB cycle so the pointer advances as it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_scrub  <= 1'b0;
      scrub_ptr <= '0;
    end else begin
      in_scrub <= scrub_take;
      if (in_scrub) scrub_ptr <= scrub_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// ECC memory controller: serializes CPU requests onto the single array port,
// interleaves background scrubbing and writes corrected words back.
module ecc_mem_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int DATA_W         = ECC_DATA_W,
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  input  logic              scrub_en,
  output logic              scrub_busy,
  output logic [7:0]        err_count
);

  ctrl_state_e       state, state_nxt;
  logic              accept;
  logic              scrub_pending;
  logic              scrub_take;
  logic [ADDR_W-1:0] scrub_ptr;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] fix_addr;
  logic [DATA_W-1:0] fix_data;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  ecc_scrub_timer #(
    .ADDR_W         (ADDR_W),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_scrub_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .scrub_en      (scrub_en),
    .scrub_take    (scrub_take),
    .scrub_pending (scrub_pending),
    .scrub_ptr     (scrub_ptr)
  );

  assign req_ready  = (state == ST_IDLE) && !scrub_pending;
  assign accept     = req_valid && req_ready;
  assign scrub_take = (state == ST_IDLE) && scrub_pending;
  assign scrub_busy = (state == ST_SCRUB) || (state == ST_FIX) || scrub_pending;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (scrub_take)  state_nxt = ST_SCRUB;
        else if (accept) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = (!lat_we && mem_err) ? ST_FIX : ST_IDLE;
      ST_SCRUB:  state_nxt = mem_err ? ST_FIX : ST_IDLE;
      ST_FIX:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Array port is decoded from state so an asynchronous reset drops mem_we at once.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_ACCESS: begin
        mem_addr  = lat_addr;
        mem_we    = lat_we;
        mem_wdata = lat_we ? lat_wdata : '0;
      end
      ST_SCRUB: mem_addr = scrub_ptr;
      ST_FIX: begin
        mem_addr  = fix_addr;
        mem_we    = 1'b1;
        mem_wdata = fix_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_count <= '0;
    end else begin
      rsp_valid <= (state == ST_ACCESS);
      if (state == ST_ACCESS) rsp_err <= !lat_we && mem_err;
      if (state == ST_ACCESS && !lat_we) rsp_rdata <= mem_rdata;
      if (state_nxt == ST_FIX) err_count <= sat_inc8(err_count);
    end
  end

  // Request and write-back latches carry data only; state guards their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
    if (state == ST_ACCESS || state == ST_SCRUB) begin
      fix_addr <= mem_addr;
      fix_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Bench for ecc_mem_ctrl: behavioural array with error injection, a reference
// memory image and scrub-pointer/error-count model.
module tb_ecc_mem_ctrl;

  localparam int DATA_W         = 20;
  localparam int ADDR_W         = 4;
  localparam int DEPTH          = 16;
  localparam int SCRUB_INTERVAL = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;
  logic              scrub_en = 1'b0;
  logic              scrub_busy;
  logic [7:0]        err_count;

  logic [DATA_W-1:0] cells   [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  err_mask = '0;

  int tests = 0;
  int fails = 0;
  int ref_errs = 0;
  int ref_ptr = 0;

  always #5 clk = ~clk;

  assign mem_rdata = cells[mem_addr];
  assign mem_err   = err_mask[mem_addr];
  always @(posedge clk) if (mem_we) cells[mem_addr] <= mem_wdata;

  ecc_mem_ctrl #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .scrub_en   (scrub_en),
    .scrub_busy (scrub_busy),
    .err_count  (err_count)
  );

  function automatic logic [7:0] exp_count();
    return (ref_errs > 255) ? 8'hFF : 8'(ref_errs);
  endfunction

  // Called just after a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int stall);
    logic [DATA_W-1:0] exp_d;
    logic              exp_fix;
    exp_fix   = !we && err_mask[a];
    exp_d     = ref_mem[a];
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    stall = 0;
    while (req_ready !== 1'b1 && stall < 20) begin
      @(negedge clk);
      stall++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_accept addr=%0d ready=%b after %0d cycles, required 1", a, req_ready, stall);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if ({rsp_valid, mem_we, mem_addr} !== {1'b0, we, a}) begin
      fails++;
      $display("FAIL access_drive got rsp_valid=%b we=%b addr=%0d, required 0/%b/%0d", rsp_valid, mem_we, mem_addr, we, a);
    end
    if (we) begin
      tests++;
      if (mem_wdata !== d) begin
        fails++;
        $display("FAIL access_wdata got %h, required %h", mem_wdata, d);
      end
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rsp_latency rsp_valid=%b at N+2, required 1", rsp_valid);
    end
    if (!we) begin
      tests++;
      if ({rsp_rdata, rsp_err} !== {exp_d, exp_fix}) begin
        fails++;
        $display("FAIL read_data addr=%0d got %h err=%b, required %h err=%b", a, rsp_rdata, rsp_err, exp_d, exp_fix);
      end
    end else begin
      ref_mem[a] = d;
    end
    if (exp_fix) begin
      ref_errs++;
      tests++;
      if ({req_ready, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, a, exp_d}) begin
        fails++;
        $display("FIX cycle FAIL fix_writeback got ready=%b we=%b addr=%0d data=%h, required 0/1/%0d/%h", req_ready, mem_we, mem_addr, mem_wdata, a, exp_d);
      end
    end
    tests++;
    if (err_count !== exp_count()) begin
      fails++;
      $display("FAIL err_count got %0d, required %0d", err_count, exp_count());
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata, err_count, scrub_busy}
        !== {1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 4'h0, 20'h0, 8'h0, 1'b0}) begin
      fails++;
      $display("FAIL %s got ready=%b rv=%b rd=%h re=%b we=%b ad=%0d wd=%h cnt=%0d busy=%b, required reset values",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata, err_count, scrub_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_asserted");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_write_read();
    int st;
    do_req(1'b1, 4'd3, 20'h5A5A5, st);
    do_req(1'b0, 4'd3, 20'h0, st);
    tests++;
    if ({rsp_rdata, rsp_err, err_count} !== {20'h5A5A5, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL write_read got %h err=%b cnt=%0d, required 5a5a5/0/0", rsp_rdata, rsp_err, err_count);
    end
  endtask

  task automatic test_read_err();
    int st;
    do_req(1'b1, 4'd7, 20'h12345, st);
    err_mask[7] = 1'b1;
    do_req(1'b0, 4'd7, 20'h0, st);
    tests++;
    if ({rsp_rdata, rsp_err} !== {20'h12345, 1'b1}) begin
      fails++;
      $display("FAIL read_err_rsp got %h err=%b, required 12345/1", rsp_rdata, rsp_err);
    end
    @(negedge clk);
    err_mask[7] = 1'b0;
    tests++;
    if ({req_ready, mem_we, rsp_valid, err_count} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL after_fix got ready=%b we=%b rv=%b cnt=%0d, required 1/0/0/1", req_ready, mem_we, rsp_valid, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom), st);
      tests++;
      if (st != 0) begin
        fails++;
        $display("FAIL back_to_back_stall op=%0d stall=%0d, required 0", i, st);
      end
    end
  endtask

  task automatic test_scrub();
    int c = 0, nscrub = 0, last = 0, we_seen = 0;
    logic prev_busy = 1'b0;
    scrub_en = 1'b1;
    while (nscrub < 20 && c < 100) begin
      @(negedge clk);
      c++;
      if (mem_we === 1'b1) we_seen++;
      if (scrub_busy === 1'b1 && prev_busy === 1'b1) begin
        tests++;
        if (mem_addr !== ADDR_W'(ref_ptr)) begin
          fails++;
          $display("FAIL scrub_addr scrub=%0d got %0d, required %0d", nscrub, mem_addr, ref_ptr);
        end
        tests++;
        if ((nscrub == 0 && c != SCRUB_INTERVAL + 1) || (nscrub != 0 && c - last != SCRUB_INTERVAL)) begin
          fails++;
          $display("FAIL scrub_spacing scrub=%0d at cycle %0d prev %0d, interval required %0d", nscrub, c, last, SCRUB_INTERVAL);
        end
        last = c;
        nscrub++;
        ref_ptr = (ref_ptr + 1) % DEPTH;
      end
      prev_busy = scrub_busy;
    end
    scrub_en = 1'b0;
    tests++;
    if (nscrub != 20) begin
      fails++;
      $display("FAIL scrub_count got %0d in %0d cycles, required 20", nscrub, c);
    end
    tests++;
    if (we_seen != 0) begin
      fails++;
      $display("FAIL scrub_no_write mem_we seen %0d times, required 0", we_seen);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (scrub_busy !== 1'b0) begin
      fails++;
      $display("FAIL scrub_idle busy=%b, required 0", scrub_busy);
    end
  endtask

  task automatic test_scrub_priority(input logic with_err);
    int st;
    logic [ADDR_W-1:0] a;
    scrub_en = 1'b0;
    @(negedge clk);
    scrub_en = 1'b1;
    repeat (SCRUB_INTERVAL) @(negedge clk);
    tests++;
    if ({scrub_busy, req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL pending_visible got busy=%b ready=%b, required 1/0", scrub_busy, req_ready);
    end
    scrub_en = 1'b0;
    a = ADDR_W'(ref_ptr + 5);
    if (with_err) begin
      err_mask[ref_ptr] = 1'b1;
      ref_errs++;
    end
    do_req(1'b0, a, 20'h0, st);
    tests++;
    if (st != (with_err ? 3 : 2)) begin
      fails++;
      $display("FAIL scrub_priority_stall err=%b got %0d, required %0d", with_err, st, with_err ? 3 : 2);
    end
    ref_ptr = (ref_ptr + 1) % DEPTH;
    err_mask = '0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int c = 0, fixes = 0;
    err_mask = '1;
    scrub_en = 1'b1;
    while (fixes < 300 && c < 2500) begin
      @(negedge clk);
      c++;
      if (mem_we === 1'b1) begin
        tests++;
        if ({mem_addr, mem_wdata} !== {ADDR_W'(ref_ptr), ref_mem[ref_ptr]}) begin
          fails++;
          $display("FAIL scrub_fix fix=%0d got addr=%0d data=%h, required %0d/%h", fixes, mem_addr, mem_wdata, ref_ptr, ref_mem[ref_ptr]);
        end
        ref_ptr = (ref_ptr + 1) % DEPTH;
        fixes++;
        ref_errs++;
      end
    end
    scrub_en = 1'b0;
    err_mask = '0;
    tests++;
    if (fixes != 300) begin
      fails++;
      $display("FAIL scrub_fix_count got %0d in %0d cycles, required 300", fixes, c);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (err_count !== 8'hFF) begin
      fails++;
      $display("FAIL err_count_saturate got %0d, required 255", err_count);
    end
  endtask

  task automatic test_reset_fix();
    int st;
    do_req(1'b1, 4'd9, 20'hABCDE, st);
    err_mask[9] = 1'b1;
    do_req(1'b0, 4'd9, 20'h0, st);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_we, rsp_valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_abort got we=%b rv=%b, required 0/0", mem_we, rsp_valid);
    end
    err_mask = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_errs = 0;
    ref_ptr = 0;
    @(negedge clk);
    check_reset_values("reset_after_fix");
    do_req(1'b1, 4'd2, 20'h0F0F0, st);
    do_req(1'b0, 4'd2, 20'h0, st);
    tests++;
    if ({rsp_rdata, rsp_err} !== {20'h0F0F0, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_read got %h err=%b, required 0f0f0/0", rsp_rdata, rsp_err);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_read_err();
    test_back_to_back();
    test_scrub();
    test_scrub_priority(1'b0);
    test_scrub_priority(1'b1);
    test_saturate();
    test_reset_fix();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
